// File: rtl/tx_sched.sv
// Round-robin scheduler that hands one byte at a time from four requesters to a
// shared transmitter, with per-byte retry on self-check error and wait-state timeouts.
module tx_sched #(
  parameter int TIMEOUT_CYC = 255,
  parameter int MAX_RETRY   = 1
) (
  input  logic        clka,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  input  logic        tx_busy,
  input  logic        tx_done,
  input  logic        tx_error,
  output logic [7:0]  tx_data,
  output logic        tx_rdy,
  output logic [3:0]  gnt,
  output logic [3:0]  ack,
  output logic [3:0]  nack,
  output logic        sched_busy,
  output logic [7:0]  err_cnt,
  output logic [2:0]  dbg_state
);

  // Handshake: tx_rdy is a single-cycle launch strobe with tx_data already stable;
  // the transmitter answers with tx_busy, then a tx_done pulse carrying tx_error.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_START     = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_CHECK     = 3'd5,
    S_OK        = 3'd6,
    S_FAIL      = 3'd7
  } state_t;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYC - 1);
  localparam logic [1:0] RETRY_MAX  = 2'(MAX_RETRY);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] owner;
  logic [1:0] last_owner;
  logic [1:0] retry_cnt;
  logic [7:0] timer;
  logic       err_q;
  logic [1:0] pick;
  logic [1:0] cand;
  logic       found;
  logic       timeout;

  // Search upward from the requester after the last owner, wrapping.
  always_comb begin
    pick  = 2'd0;
    cand  = 2'd0;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_owner + 2'(k);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  // timer holds the number of cycles already spent in the current wait state
  assign timeout = (timer == TIMER_LAST);

  always_ff @(posedge clka or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (found) state_nxt = S_LOAD;
      S_LOAD:      state_nxt = S_START;
      S_START:     state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (tx_busy)      state_nxt = S_WAIT_DONE;
        else if (timeout) state_nxt = S_FAIL;
      end
      S_WAIT_DONE: begin
        if (tx_done)      state_nxt = S_CHECK;
        else if (timeout) state_nxt = S_FAIL;
      end
      S_CHECK: begin
        if (!err_q)                     state_nxt = S_OK;
        else if (retry_cnt < RETRY_MAX) state_nxt = S_START;
        else                            state_nxt = S_FAIL;
      end
      S_OK:        state_nxt = S_IDLE;
      S_FAIL:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clka or negedge reset) begin
    if (!reset) begin
      tx_data    <= 8'd0;
      gnt        <= 4'd0;
      owner      <= 2'd0;
      last_owner <= 2'd3;
      retry_cnt  <= 2'd0;
      timer      <= 8'd0;
      err_q      <= 1'b0;
      err_cnt    <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            owner <= pick;
            gnt   <= 4'b0001 << pick;
          end
        end
        S_LOAD: begin
          tx_data   <= req_data[{owner, 3'b000} +: 8];
          retry_cnt <= 2'd0;
        end
        S_START: timer <= 8'd0;
        S_WAIT_BUSY: begin
          if (tx_busy)              timer <= 8'd0;
          else if (timer != 8'hFF)  timer <= timer + 8'd1;
        end
        S_WAIT_DONE: begin
          if (tx_done)              err_q <= tx_error;
          else if (timer != 8'hFF)  timer <= timer + 8'd1;
        end
        S_CHECK: begin
          if (err_q && (retry_cnt < RETRY_MAX)) retry_cnt <= retry_cnt + 2'd1;
        end
        S_OK: begin
          last_owner <= owner;
          gnt        <= 4'd0;
        end
        S_FAIL: begin
          last_owner <= owner;
          gnt        <= 4'd0;
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tx_rdy     = (state == S_START);
    ack        = (state == S_OK)   ? gnt : 4'd0;
    nack       = (state == S_FAIL) ? gnt : 4'd0;
    sched_busy = (state != S_IDLE);
    dbg_state  = state;
  end

endmodule

// File: tb/tb_tx_sched.sv
// Randomized bench for tx_sched: transaction-level reference (round-robin pick,
// retry/timeout outcome, saturating error count) checked against the DUT.
module tb_tx_sched;
  localparam int TIMEOUT_CYC = 255;
  localparam int MAX_RETRY   = 1;

  logic        clka = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req = 4'd0;
  logic [31:0] req_data = 32'd0;
  logic        tx_busy = 1'b0;
  logic        tx_done = 1'b0;
  logic        tx_error = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_rdy;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic [3:0]  nack;
  logic        sched_busy;
  logic [7:0]  err_cnt;
  logic [2:0]  dbg_state;

  tx_sched #(.TIMEOUT_CYC(TIMEOUT_CYC), .MAX_RETRY(MAX_RETRY)) dut (
    .clka(clka), .reset(reset), .req(req), .req_data(req_data),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error),
    .tx_data(tx_data), .tx_rdy(tx_rdy), .gnt(gnt), .ack(ack), .nack(nack),
    .sched_busy(sched_busy), .err_cnt(err_cnt), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clka = ~clka;

  int checks = 0;
  int failures = 0;
  int rdy_cnt = 0;
  int ack_cnt = 0;
  int nack_cnt = 0;
  int m_last = 3;
  int m_err = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clka);
    if (tx_rdy)    rdy_cnt++;
    if (ack != 0)  ack_cnt++;
    if (nack != 0) nack_cnt++;
  endtask

  function automatic int rr_pick(input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      if (r[(m_last + k) % 4]) return (m_last + k) % 4;
    end
    return 0;
  endfunction

  // One complete transfer, starting and ending at a negedge with the DUT idle.
  task automatic xfer(input logic [3:0] r, input logic [31:0] d, input int n_err,
                      input bit to, input bit drop);
    int o, att, c_rdy, c_ack, c_nack, bd, bl;
    bit fail;
    logic [3:0] g;
    logic [7:0] b;
    o    = rr_pick(r);
    g    = 4'(1 << o);
    b    = 8'(d >> (8 * o));
    fail = to || (n_err > MAX_RETRY);
    att  = to ? 1 : ((n_err > MAX_RETRY) ? MAX_RETRY + 1 : n_err + 1);
    c_rdy = rdy_cnt; c_ack = ack_cnt; c_nack = nack_cnt;
    for (int a = 0; a < att; a++) exp_q.push_back(b);
    req = r; req_data = d;
    tick();
    check("gnt", 32'(gnt), 32'(g));
    check("sched_busy", 32'(sched_busy), 32'd1);
    tick();
    check("lat_rdy", 32'(tx_rdy), 32'd1);
    for (int a = 0; a < att; a++) begin
      check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
      if (drop && a == 0) req = r & ~g;
      if (to) begin
        repeat (TIMEOUT_CYC + 1) tick();
      end else begin
        bd = $urandom_range(0, 3);
        bl = $urandom_range(2, 4);
        repeat (bd) tick();
        tx_busy = 1'b1;
        repeat (bl) tick();
        tx_busy = 1'b0; tx_done = 1'b1; tx_error = (a < n_err);
        tick();
        tx_done = 1'b0; tx_error = 1'b0;
        tick();
        if (a < att - 1) check("retry_rdy", 32'(tx_rdy), 32'd1);
      end
    end
    check("ack", 32'(ack), fail ? 32'd0 : 32'(g));
    check("nack", 32'(nack), fail ? 32'(g) : 32'd0);
    check("tx_data_hold", 32'(tx_data), 32'(b));
    tick();
    if (fail && m_err < 255) m_err++;
    m_last = o;
    req = 4'd0;
    check("err_cnt", 32'(err_cnt), 32'(m_err));
    check("gnt_clear", 32'(gnt), 32'd0);
    check("idle", 32'(sched_busy), 32'd0);
    check("rdy_pulses", 32'(rdy_cnt - c_rdy), 32'(att));
    check("ack_pulses", 32'(ack_cnt - c_ack), fail ? 32'd0 : 32'd1);
    check("nack_pulses", 32'(nack_cnt - c_nack), fail ? 32'd1 : 32'd0);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] r;
    int c_ack, c_nack;
    repeat (2) tick();
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_tx_rdy", 32'(tx_rdy), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_busy", 32'(sched_busy), 32'd0);
    check("rst_acknack", 32'({ack, nack}), 32'd0);
    reset = 1'b1;
    tick();

    // single request, owner 2
    xfer(4'b0100, 32'h00A5_0000, 0, 1'b0, 1'b0);
    // fairness with all requesting
    for (int i = 0; i < 5; i++) xfer(4'b1111, $urandom, 0, 1'b0, 1'b0);
    // one retry then success
    xfer(4'b1010, $urandom, 1, 1'b0, 1'b0);
    // wait-busy timeout
    xfer(4'b0001, $urandom, 0, 1'b1, 1'b0);
    // requester drop
    xfer(4'b0010, $urandom, 0, 1'b0, 1'b1);
    // random mix
    for (int i = 0; i < 30; i++) begin
      r = 4'($urandom_range(1, 15));
      xfer(r, $urandom, $urandom_range(0, 2), 1'b0, 1'($urandom_range(0, 1)));
    end
    // drive err_cnt into saturation with exhausted retries
    for (int i = 0; i < 256; i++) begin
      r = 4'($urandom_range(1, 15));
      xfer(r, $urandom, 2, 1'b0, 1'b0);
    end
    check("err_sat", 32'(err_cnt), 32'd255);

    // reset while waiting for tx_done
    req = 4'b0100; req_data = $urandom;
    tick(); tick();
    tx_busy = 1'b1;
    tick(); tick();
    tx_busy = 1'b0;
    c_ack = ack_cnt; c_nack = nack_cnt;
    #2 reset = 1'b0;
    #1;
    check("mid_rst_rdy", 32'(tx_rdy), 32'd0);
    check("mid_rst_gnt", 32'(gnt), 32'd0);
    check("mid_rst_busy", 32'(sched_busy), 32'd0);
    check("mid_rst_err", 32'(err_cnt), 32'd0);
    check("mid_rst_data", 32'(tx_data), 32'd0);
    req = 4'd0;
    tx_done = 1'b1;
    repeat (3) tick();
    tx_done = 1'b0;
    check("mid_rst_noack", 32'(ack_cnt - c_ack), 32'd0);
    check("mid_rst_nonack", 32'(nack_cnt - c_nack), 32'd0);
    reset = 1'b1;
    m_last = 3; m_err = 0;
    tick();
    // first grant after reset goes to requester 0
    xfer(4'b1111, $urandom, 0, 1'b0, 1'b0);
    xfer(4'b1001, $urandom, 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
